// File: rtl/gbmidi_pkg.sv
// Shared widths, default voice count and allocator FSM states.
package gbmidi_pkg;
   localparam int NV     = 8;
   localparam int NOTE_W = 7;
   localparam int VEL_W  = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;
endpackage

// File: rtl/gb_voice_ranker.sv
// Age-rank update: the allocated voice becomes youngest (rank 0) and every
// voice that was younger than it ages by one, keeping ranks a permutation.
module gb_voice_ranker #(
   parameter int NV = 8,
   parameter int AW = 3
) (
   input  logic [NV-1:0][AW-1:0] rank_in,
   input  logic [AW-1:0]         alloc_idx,
   output logic [NV-1:0][AW-1:0] rank_out
);
   logic [AW-1:0] alloc_rank;

   assign alloc_rank = rank_in[alloc_idx];

   // Combinational rank shuffle around the allocated voice.
   always_comb begin
      rank_out = rank_in;
      for (int i = 0; i < NV; i++) begin
         if (AW'(i) == alloc_idx) begin
            rank_out[i] = '0;
         end else if (rank_in[i] < alloc_rank) begin
            rank_out[i] = rank_in[i] + AW'(1);
         end
      end
   end
endmodule

// File: rtl/gb_voice_alloc.sv
// Polyphonic voice allocator: latches one note event, scans one voice per
// cycle for match/free/oldest candidates, then commits in a single cycle.
module gb_voice_alloc
   import gbmidi_pkg::*;
#(
   parameter int NV = gbmidi_pkg::NV,
   parameter int AW = $clog2(NV)
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic                 ev_valid,
   output logic                 ev_ready,
   input  logic                 ev_on,
   input  logic [NOTE_W-1:0]    ev_note,
   input  logic [VEL_W-1:0]     ev_vel,
   input  logic [NV-1:0]        voice_en,
   input  logic                 all_off,
   output logic [NV*NOTE_W-1:0] voice_note,
   output logic [NV*VEL_W-1:0]  voice_vel,
   output logic [NV-1:0]        voice_gate,
   output logic [NV-1:0]        voice_trig,
   output logic                 steal,
   output logic                 drop,
   output state_t               fsm_state
);
   state_t                   state;
   logic                     alive;
   logic [AW-1:0]            scan_idx;
   logic                     ev_on_q;
   logic [NOTE_W-1:0]        ev_note_q;
   logic [VEL_W-1:0]         ev_vel_q;
   logic                     match_found, free_found, old_found;
   logic [AW-1:0]            match_idx, free_idx, old_idx, old_rank;
   logic [NV-1:0]            gate_q, trig_q;
   logic                     steal_q, drop_q;
   logic [NV-1:0][NOTE_W-1:0] note_q;
   logic [NV-1:0][VEL_W-1:0]  vel_q;
   logic [NV-1:0][AW-1:0]    age_q, age_next;
   logic                     eff_on, sel_valid, sel_steal, last_voice;
   logic [AW-1:0]            sel_idx;

   // Handshake: an event transfers on a clk_sys edge where ev_valid and
   // ev_ready are both 1; ev_ready is high only while idle, out of reset,
   // and not being overridden by all_off. ev_valid must hold until then.
   assign ev_ready   = alive && (state == ST_IDLE) && !all_off;
   assign eff_on     = ev_on_q && (ev_vel_q != '0);
   assign last_voice = (scan_idx == AW'(NV - 1));

   assign voice_note = note_q;
   assign voice_vel  = vel_q;
   assign voice_gate = gate_q;
   assign voice_trig = trig_q;
   assign steal      = steal_q;
   assign drop       = drop_q;
   assign fsm_state  = state;

   // Note-on target priority: retrigger a matching voice, else a free one, else steal the oldest.
   always_comb begin
      sel_idx   = match_idx;
      sel_valid = 1'b0;
      sel_steal = 1'b0;
      if (match_found) begin
         sel_valid = 1'b1;
      end else if (free_found) begin
         sel_idx   = free_idx;
         sel_valid = 1'b1;
      end else if (old_found) begin
         sel_idx   = old_idx;
         sel_valid = 1'b1;
         sel_steal = 1'b1;
      end
   end

   gb_voice_ranker #(.NV(NV), .AW(AW)) u_ranker (
      .rank_in   (age_q),
      .alloc_idx (sel_idx),
      .rank_out  (age_next)
   );

   // Allocator FSM plus all per-voice state; pulses default low every cycle.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         alive       <= 1'b0;
         scan_idx    <= '0;
         ev_on_q     <= 1'b0;
         ev_note_q   <= '0;
         ev_vel_q    <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
         match_idx   <= '0;
         free_idx    <= '0;
         old_idx     <= '0;
         old_rank    <= '0;
         gate_q      <= '0;
         trig_q      <= '0;
         steal_q     <= 1'b0;
         drop_q      <= 1'b0;
         note_q      <= '0;
         vel_q       <= '0;
         for (int i = 0; i < NV; i++) age_q[i] <= AW'(i);
      end else begin
         alive   <= 1'b1;
         trig_q  <= '0;
         steal_q <= 1'b0;
         drop_q  <= 1'b0;
         if (all_off) begin
            // Panic: silence everything and drop whatever event was in flight.
            gate_q <= '0;
            state  <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  gate_q <= gate_q & voice_en;
                  if (ev_valid && ev_ready) begin
                     ev_on_q     <= ev_on;
                     ev_note_q   <= ev_note;
                     ev_vel_q    <= ev_vel;
                     match_found <= 1'b0;
                     free_found  <= 1'b0;
                     old_found   <= 1'b0;
                     scan_idx    <= '0;
                     state       <= ST_SCAN;
                  end
               end
               ST_SCAN: begin
                  // voice_en is sampled only for the voice under inspection.
                  if (voice_en[scan_idx]) begin
                     if (!match_found && gate_q[scan_idx] &&
                         (note_q[scan_idx] == ev_note_q)) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                     end
                     if (!free_found && !gate_q[scan_idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                     end
                     if (!old_found || (age_q[scan_idx] > old_rank)) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                        old_rank  <= age_q[scan_idx];
                     end
                  end
                  if (last_voice) state <= ST_COMMIT;
                  else            scan_idx <= scan_idx + AW'(1);
               end
               ST_COMMIT: begin
                  if (eff_on) begin
                     if (sel_valid) begin
                        note_q[sel_idx] <= ev_note_q;
                        vel_q[sel_idx]  <= ev_vel_q;
                        gate_q[sel_idx] <= 1'b1;
                        trig_q[sel_idx] <= 1'b1;
                        steal_q         <= sel_steal;
                        age_q           <= age_next;
                     end else begin
                        drop_q <= 1'b1;
                     end
                  end else if (match_found) begin
                     gate_q[match_idx] <= 1'b0;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/gb_voice_alloc.md
GB_VOICE_ALLOC -- requirements
Module: gb_voice_alloc

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter NV, default 8, SHALL set the number of voices (P1+P2 x4 auto-polyphony).
REQ-003 Parameter AW, default 3, SHALL equal clog2(NV) and set the voice-index width.
REQ-004 clk_sys  in  1  system clock.
REQ-005 reset_n  in  1  async active-low reset.
REQ-006 ev_valid  in  1  note event present.
REQ-007 ev_ready  out  1  block accepts event (transfer when ev_valid & ev_ready).
REQ-008 ev_on  in  1  1=note-on, 0=note-off.
REQ-009 ev_note  in  7  MIDI note number.
REQ-010 ev_vel  in  7  MIDI velocity.
REQ-011 voice_en  in  NV  per-voice enable mask (poly_en-derived).
REQ-012 all_off  in  1  single-cycle all-notes-off request (CC123).
REQ-013 voice_note  out  NV*7  packed note per voice (voice i at [7i+6:7i]).
REQ-014 voice_vel  out  NV*7  packed velocity per voice.
REQ-015 voice_gate  out  NV  voice sounding.
REQ-016 voice_trig  out  NV  one-cycle (re)trigger pulse per voice.
REQ-017 steal  out  1  one-cycle pulse when an active voice was stolen.
REQ-018 drop  out  1  one-cycle pulse when a note-on found no enabled voice.

Function
REQ-019 The FSM SHALL have states IDLE, SCAN, COMMIT; ev_ready SHALL be 1 only in IDLE with all_off=0.
REQ-020 On transfer, the event SHALL be latched and the FSM SHALL go to SCAN.
REQ-021 SCAN SHALL examine exactly one voice per cycle, index 0..NV-1, then go to COMMIT (NV cycles).
REQ-022 The scan SHALL record: first enabled voice whose gate=1 and note=ev_note (match); lowest-index enabled voice with gate=0 (free); enabled voice with highest age rank (oldest).
REQ-023 A note-on with ev_vel=0 SHALL be treated as note-off.
REQ-024 Note-on selection SHALL be: match, else free, else oldest (steal=1), else none (drop=1).
REQ-025 On note-on commit, the selected voice SHALL take note/vel, gate=1, and voice_trig SHALL pulse for one cycle after COMMIT.
REQ-026 Note-off commit SHALL clear gate of the match voice only; note/vel SHALL hold; no match SHALL change nothing.
REQ-027 Age ranks SHALL be a permutation of 0..NV-1; on allocation of voice v with rank a, every voice with rank < a SHALL increment and v SHALL become 0.
REQ-028 COMMIT SHALL last one cycle and return to IDLE; event-to-output latency SHALL be NV+1 cycles after transfer.
REQ-029 all_off=1 in any state SHALL clear all gates on the next edge, return the FSM to IDLE, and discard any in-flight event.
REQ-030 In IDLE, any voice with voice_en=0 and gate=1 SHALL have its gate cleared on the next edge.
REQ-031 voice_en changes during SCAN SHALL take effect on the voice only when it is scanned.
REQ-032 steal, drop and voice_trig SHALL be mutually consistent: at most one voice_trig bit per commit.

Reset
REQ-033 Under reset_n=0: state IDLE, ev_ready=0, gates/notes/vels/trig/steal/drop=0, age rank of voice i = i.
REQ-034 ev_ready SHALL rise on the first clk_sys edge after reset_n deasserts.

Structure
REQ-035 Package gbmidi_pkg SHALL hold NV, note/velocity widths and the FSM state enum.
REQ-036 Age-rank update SHALL be a sub-module gb_voice_ranker (rank array in, allocated index in, rank array out).

Verification
REQ-037 Reset, en=FF, note-on 60/100 -> after 9 cycles voice 0 note=60, gate=1, trig[0] one cycle.
REQ-038 Note-on 60,62 then note-on 60/90 -> voice 0 retriggered, vel=90, voice 1 unchanged.
REQ-039 Nine note-ons 60..68 -> ninth steals voice 0 (oldest), steal=1, note=68.
REQ-040 en=00000001, two note-ons -> second steals voice 0; en=00 -> note-on gives drop=1, no gate change.
REQ-041 all_off mid-SCAN -> gates all 0 next cycle, event discarded, ev_ready=1 in IDLE.
REQ-042 Note-on 64 then note-on 64/vel 0 -> gate[0]=0, note[0] stays 64.
